// File: rtl/ddr_frame_pkg.sv
// ddr_frame_pkg
// Shared definitions for the DDR frame arbiter: scheduler state encoding,
// bank index width, default burst count per frame and the bank rotation helper.
package ddr_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam int BANK_W          = 2;
    localparam int DEF_FRAME_WORDS = 65280;
    localparam int DEF_BURST_LEN   = 64;
    localparam int FRAME_BURSTS    = DEF_FRAME_WORDS / DEF_BURST_LEN;

    // Banks are 0,1,2, so the one that is neither a nor b is 3-a-b.
    function automatic logic [BANK_W-1:0] third_bank(input logic [BANK_W-1:0] a,
                                                     input logic [BANK_W-1:0] b);
        return BANK_W'(3) - a - b;
    endfunction

endpackage

// File: rtl/frame_bank_ctrl.sv
// frame_bank_ctrl
// Triple-buffer bank rotation. Tracks the bank being written, the bank being
// read and the most recently completed (published) bank.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_done      write frame completed this cycle: publish wr_bank, rotate
//   rd_start     reader (re)starts this cycle: read the latest published bank
//   wr_bank      bank being written
//   rd_bank      bank being read
module frame_bank_ctrl
    import ddr_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_done,
    input  logic              rd_start,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank
);

    logic [BANK_W-1:0] latest;
    logic              latest_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank      <= '0;
            rd_bank      <= BANK_W'(2);
            latest       <= BANK_W'(2);
            latest_valid <= 1'b0;
        end else begin
            if (wr_done) begin
                latest       <= wr_bank;
                latest_valid <= 1'b1;
                if (rd_start) begin
                    // Reader jumps onto the frame just finished; the writer
                    // takes over the bank the reader leaves.
                    rd_bank <= wr_bank;
                    wr_bank <= rd_bank;
                end else begin
                    wr_bank <= third_bank(wr_bank, rd_bank);
                end
            end else if (rd_start && latest_valid) begin
                // Before the first publish rd_bank already equals latest.
                rd_bank <= latest;
            end
        end
    end

endmodule

// File: rtl/ddr_frame_arbiter.sv
// ddr_frame_arbiter
// Shares one DDR burst engine between the camera write FIFO (drain to DDR)
// and the LCD read FIFO (fill from DDR). One fixed-length burst outstanding
// at a time, round-robin when both sides are eligible.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ddr_init_done                  no new command while low
//   wr_frame_start, rd_frame_start frame-begin pulses (arm / restart a side)
//   wr_fifo_level, rd_fifo_level   FIFO fill levels
//   cmd_valid/cmd_ready            command handshake
//   cmd_write, cmd_addr            direction (1 = FIFO to DDR) and word address
//   burst_done                     accepted burst fully transferred
//   wr_bank, rd_bank               current write / read banks
//   frame_write_done/read_done     one-cycle frame completion pulses
//   busy                           command outstanding
module ddr_frame_arbiter
    import ddr_frame_pkg::*;
#(
    parameter int          ADDR_W        = 24,
    parameter int          LVL_W         = 10,
    parameter int          BURST_LEN     = 64,
    parameter int          FRAME_WORDS   = 65280,
    parameter int unsigned BANK_STRIDE   = 32'h0002_0000,
    parameter int          RD_FIFO_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ddr_init_done,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_level,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              burst_done,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank,
    output logic              frame_write_done,
    output logic              frame_read_done,
    output logic              busy
);

    localparam int               N_BURSTS = FRAME_WORDS / BURST_LEN;
    localparam int               CNT_W    = $clog2(N_BURSTS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BURSTS - 1);
    localparam logic [LVL_W-1:0] WR_MIN   = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] RD_MAX   = LVL_W'(RD_FIFO_DEPTH - BURST_LEN);

    arb_state_t        state, state_next;
    logic              grant_write, last_write;
    logic              wr_armed, rd_armed, wr_pend, rd_pend;
    logic [CNT_W-1:0]  wr_cnt, rd_cnt;

    logic              w_elig, r_elig, pick_write, issue;
    logic              wr_bdone, rd_bdone, wr_in_flight, rd_in_flight;
    logic              wr_restart, rd_restart, wr_complete, rd_complete;
    logic [ADDR_W-1:0] next_addr;

    assign w_elig     = ddr_init_done & wr_armed & (wr_fifo_level >= WR_MIN);
    assign r_elig     = ddr_init_done & rd_armed & (rd_fifo_level <= RD_MAX);
    // last_write resets to 0 so the writer wins the first contested grant.
    assign pick_write = w_elig & (~r_elig | ~last_write);
    assign issue      = (state == ST_IDLE) & (w_elig | r_elig);

    assign wr_bdone   = (state == ST_WAIT) & burst_done &  grant_write;
    assign rd_bdone   = (state == ST_WAIT) & burst_done & ~grant_write;

    // A burst being granted this very cycle already used the old bank/count,
    // so a frame start arriving now must be deferred like any in-flight one.
    assign wr_in_flight = ((state != ST_IDLE) &  grant_write) | (issue &  pick_write);
    assign rd_in_flight = ((state != ST_IDLE) & ~grant_write) | (issue & ~pick_write);

    assign wr_restart = wr_bdone ? (wr_pend | wr_frame_start) : (wr_frame_start & ~wr_in_flight);
    assign rd_restart = rd_bdone ? (rd_pend | rd_frame_start) : (rd_frame_start & ~rd_in_flight);

    // Completion looks at the count before any restart clears it.
    assign wr_complete = wr_bdone & (wr_cnt == LAST_CNT);
    assign rd_complete = rd_bdone & (rd_cnt == LAST_CNT);

    assign next_addr = pick_write
        ? ADDR_W'(wr_bank) * ADDR_W'(BANK_STRIDE) + ADDR_W'(wr_cnt) * ADDR_W'(BURST_LEN)
        : ADDR_W'(rd_bank) * ADDR_W'(BANK_STRIDE) + ADDR_W'(rd_cnt) * ADDR_W'(BURST_LEN);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (issue)      state_next = ST_CMD;
            ST_CMD:  if (cmd_ready)  state_next = ST_WAIT;
            ST_WAIT: if (burst_done) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid        <= 1'b0;
            cmd_write        <= 1'b0;
            cmd_addr         <= '0;
            grant_write      <= 1'b0;
            last_write       <= 1'b0;
            wr_armed         <= 1'b0;
            rd_armed         <= 1'b0;
            wr_pend          <= 1'b0;
            rd_pend          <= 1'b0;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            frame_write_done <= 1'b0;
            frame_read_done  <= 1'b0;
        end else begin
            frame_write_done <= wr_complete;
            frame_read_done  <= rd_complete;

            if (issue) begin
                cmd_valid   <= 1'b1;
                cmd_write   <= pick_write;
                cmd_addr    <= next_addr;
                grant_write <= pick_write;
                last_write  <= pick_write;
            end else if ((state == ST_CMD) && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            if (wr_restart) begin
                wr_armed <= 1'b1;
                wr_cnt   <= '0;
            end else begin
                if (wr_bdone)    wr_cnt   <= wr_cnt + 1'b1;
                if (wr_complete) wr_armed <= 1'b0;
            end
            if (wr_bdone)                            wr_pend <= 1'b0;
            else if (wr_frame_start && wr_in_flight) wr_pend <= 1'b1;

            if (rd_restart) begin
                rd_armed <= 1'b1;
                rd_cnt   <= '0;
            end else begin
                if (rd_bdone)    rd_cnt   <= rd_cnt + 1'b1;
                if (rd_complete) rd_armed <= 1'b0;
            end
            if (rd_bdone)                            rd_pend <= 1'b0;
            else if (rd_frame_start && rd_in_flight) rd_pend <= 1'b1;
        end
    end

    frame_bank_ctrl u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_done  (wr_complete),
        .rd_start (rd_restart),
        .wr_bank  (wr_bank),
        .rd_bank  (rd_bank)
    );

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// tb_ddr_frame_arbiter
// Directed scenarios with an expected-event scoreboard. Stimulus pushes the
// expected commands and frame-done pulses; a monitor pops and compares them
// as the DUT produces them. A small engine model answers each handshake with
// burst_done three cycles later.
module tb_ddr_frame_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ddr_init_done;
    logic        wr_frame_start;
    logic        rd_frame_start;
    logic [9:0]  wr_fifo_level;
    logic [9:0]  rd_fifo_level;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [23:0] cmd_addr;
    logic        burst_done;
    logic [1:0]  wr_bank;
    logic [1:0]  rd_bank;
    logic        frame_write_done;
    logic        frame_read_done;
    logic        busy;

    ddr_frame_arbiter #(
        .ADDR_W        (24),
        .LVL_W         (10),
        .BURST_LEN     (4),
        .FRAME_WORDS   (16),
        .BANK_STRIDE   (64),
        .RD_FIFO_DEPTH (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ddr_init_done    (ddr_init_done),
        .wr_frame_start   (wr_frame_start),
        .rd_frame_start   (rd_frame_start),
        .wr_fifo_level    (wr_fifo_level),
        .rd_fifo_level    (rd_fifo_level),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .burst_done       (burst_done),
        .wr_bank          (wr_bank),
        .rd_bank          (rd_bank),
        .frame_write_done (frame_write_done),
        .frame_read_done  (frame_read_done),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_CMD = 0, K_WDONE = 1, K_RDONE = 2;

    typedef struct {
        int          kind;
        logic        wr;
        logic [23:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   hs_count = 0;
    int   pend_cyc = 0;
    logic hold_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_evt(input int kind, input logic w, input int a);
        exp_t e;
        e.kind = kind;
        e.wr   = w;
        e.addr = 24'(a);
        exp_q.push_back(e);
    endtask

    task automatic expect_evt(input int kind, input logic w, input logic [23:0] a);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard unexpected event: actual kind=%0d wr=%0b addr=%0d, required none", kind, w, a);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == K_CMD && (e.wr !== w || e.addr !== a))) begin
                errors++;
                $display("FAIL scoreboard actual kind=%0d wr=%0b addr=%0d required kind=%0d wr=%0b addr=%0d",
                         kind, w, a, e.kind, e.wr, e.addr);
            end
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain timeout: actual %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_wr();
        wr_frame_start = 1'b1;
        @(negedge clk);
        wr_frame_start = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_frame_start = 1'b1;
        @(negedge clk);
        rd_frame_start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
        chk({tag, "_cmd_write"}, 32'(cmd_write), 0);
        chk({tag, "_cmd_addr"},  32'(cmd_addr), 0);
        chk({tag, "_wr_bank"},   32'(wr_bank), 0);
        chk({tag, "_rd_bank"},   32'(rd_bank), 2);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_wdone"},     32'(frame_write_done), 0);
        chk({tag, "_rdone"},     32'(frame_read_done), 0);
    endtask

    // Engine model: burst_done three cycles after each handshake.
    initial begin
        cmd_ready  = 1'b0;
        burst_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            burst_done = 1'b0;
            cmd_ready  = ~hold_ready;
            if (!rst_n) begin
                pend_cyc = 0;
            end else if (pend_cyc > 0) begin
                pend_cyc--;
                if (pend_cyc == 0) burst_done = 1'b1;
            end else if (cmd_valid && cmd_ready) begin
                pend_cyc = 3;
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT event.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (wr_bank == rd_bank) begin
                errors++;
                $display("FAIL bank_invariant actual wr_bank=%0d rd_bank=%0d required different", wr_bank, rd_bank);
            end
            if (frame_write_done) expect_evt(K_WDONE, 1'b0, 24'd0);
            if (frame_read_done)  expect_evt(K_RDONE, 1'b0, 24'd0);
            if (cmd_valid && cmd_ready) begin
                hs_count++;
                expect_evt(K_CMD, cmd_write, cmd_addr);
            end
        end
    end

    initial begin
        int nwd;
        int h0;
        int c;
        rst_n          = 1'b0;
        ddr_init_done  = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        wr_fifo_level  = '0;
        rd_fifo_level  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        rst_n         = 1'b1;
        ddr_init_done = 1'b1;
        wr_fifo_level = 10'd8;
        rd_fifo_level = 10'd20;
        @(negedge clk);

        // One full write frame into bank 0.
        for (int i = 0; i < 4; i++) push_evt(K_CMD, 1'b1, i * 4);
        push_evt(K_WDONE, 1'b0, 0);
        pulse_wr();
        wait_drain("write_frame", 300);
        chk("t1_wr_bank", 32'(wr_bank), 1);
        chk("t1_rd_bank", 32'(rd_bank), 2);
        $display("txn write_frame done wr_bank=%0d rd_bank=%0d", wr_bank, rd_bank);

        // One full read frame from the published bank 0.
        rd_fifo_level = 10'd0;
        for (int i = 0; i < 4; i++) push_evt(K_CMD, 1'b0, i * 4);
        push_evt(K_RDONE, 1'b0, 0);
        pulse_rd();
        chk("t2_rd_bank", 32'(rd_bank), 0);
        wait_drain("read_frame", 300);
        $display("txn read_frame done rd_bank=%0d", rd_bank);

        // Both eligible: strict alternation W,R,... Reader restarted on the
        // same cycle as the write completion (wr_bank=1, rd_bank=0).
        push_evt(K_CMD, 1'b1, 64); push_evt(K_CMD, 1'b0, 0);
        push_evt(K_CMD, 1'b1, 68); push_evt(K_CMD, 1'b0, 4);
        push_evt(K_CMD, 1'b1, 72); push_evt(K_CMD, 1'b0, 8);
        push_evt(K_CMD, 1'b1, 76); push_evt(K_WDONE, 1'b0, 0);
        for (int i = 0; i < 4; i++) push_evt(K_CMD, 1'b0, 64 + i * 4);
        push_evt(K_RDONE, 1'b0, 0);
        wr_frame_start = 1'b1;
        rd_frame_start = 1'b1;
        @(negedge clk);
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        nwd = 0;
        for (int i = 0; i < 300 && nwd < 4; i++) begin
            @(negedge clk);
            if (burst_done && cmd_write) begin
                nwd++;
                if (nwd == 4) rd_frame_start = 1'b1;
            end
        end
        chk("t3_write_bursts_seen", 32'(nwd), 4);
        @(negedge clk);
        rd_frame_start = 1'b0;
        chk("t3_swap_wr_bank", 32'(wr_bank), 0);
        chk("t3_swap_rd_bank", 32'(rd_bank), 1);
        wait_drain("alternate", 400);
        $display("txn alternate+swap done wr_bank=%0d rd_bank=%0d", wr_bank, rd_bank);

        // Back-pressure: command must hold still, exactly one handshake.
        hold_ready = 1'b1;
        push_evt(K_CMD, 1'b1, 0);
        pulse_wr();
        c = 0;
        while (!cmd_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        h0 = hs_count;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", 32'(cmd_valid), 1);
            chk("t4_hold_addr",  32'(cmd_addr), 0);
            chk("t4_hold_write", 32'(cmd_write), 1);
            @(negedge clk);
        end
        hold_ready = 1'b0;
        wait_drain("backpressure", 50);
        repeat (2) @(negedge clk);
        chk("t4_handshakes", 32'(hs_count - h0), 1);
        $display("txn backpressure done handshakes=%0d", hs_count - h0);

        // Restart during WAIT of burst #2: next write goes back to the base.
        push_evt(K_CMD, 1'b1, 4);
        push_evt(K_CMD, 1'b1, 0);
        c = 0;
        while (!(busy && !cmd_valid && cmd_write && cmd_addr == 24'd4) && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("t5_reached_wait2", 32'(c < 50), 1);
        pulse_wr();
        c = 0;
        while (!(busy && !cmd_valid && cmd_write && cmd_addr == 24'd0) && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("t5_reached_restart_wait", 32'(c < 50), 1);
        chk("t5_queue_empty", 32'(exp_q.size()), 0);
        $display("txn restart done addr=%0d", cmd_addr);

        // Asynchronous reset in the middle of WAIT.
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        $display("txn async_reset done busy=%0b rd_bank=%0d", busy, rd_bank);
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_frame_arbiter.md
Name: ddr_frame_arbiter

Overview:
- Single-clock scheduler that shares one DDR burst engine between the camera write FIFO (drain to DDR) and the LCD read FIFO (fill from DDR).
- Owns triple-buffer bank rotation so the LCD always scans the most recently completed camera frame and never the bank being written.
- Issues one fixed-length burst command at a time (address + direction) and produces frame-done pulses.
- Sits between the two-FIFO wrapper and the DDR controller user port.

Parameters:
- ADDR_W, 24, DDR word-address width.
- LVL_W, 10, FIFO used-word count width.
- BURST_LEN, 64, words per burst; fixed, not issued on a port.
- FRAME_WORDS, 65280, 32-bit words per frame (480x272 RGB565); must be a multiple of BURST_LEN.
- BANK_STRIDE, 24'h020000, word-address distance between bank bases.
- RD_FIFO_DEPTH, 1024, read FIFO capacity in words.

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- ddr_init_done  in  1  no command issued while low.
- wr_frame_start  in  1  one-cycle pulse: camera frame begins.
- rd_frame_start  in  1  one-cycle pulse: LCD frame begins.
- wr_fifo_level  in  LVL_W  words waiting in the write FIFO.
- rd_fifo_level  in  LVL_W  words held in the read FIFO.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  engine accepts command when high with cmd_valid.
- cmd_write  out  1  1 = FIFO-to-DDR, 0 = DDR-to-FIFO.
- cmd_addr  out  ADDR_W  burst start word address.
- burst_done  in  1  one-cycle pulse: accepted burst fully transferred.
- wr_bank  out  2  bank being written.
- rd_bank  out  2  bank being read.
- frame_write_done  out  1  one-cycle pulse: full frame written.
- frame_read_done  out  1  one-cycle pulse: full frame read.
- busy  out  1  command outstanding (CMD or WAIT).

Behaviour:
- Reset values: cmd_valid=0, cmd_write=0, cmd_addr=0, wr_bank=0, rd_bank=2, latest=2, latest_valid=0, frame_write_done=0, frame_read_done=0, busy=0. Writer and reader are disarmed; burst counters are 0.
- Eligibility:
  - W_elig = ddr_init_done & writer armed & wr_fifo_level >= BURST_LEN.
  - R_elig = ddr_init_done & reader armed & rd_fifo_level <= RD_FIFO_DEPTH - BURST_LEN.
- Arming:
  - wr_frame_start arms the writer and clears wr_cnt.
  - rd_frame_start arms the reader, clears rd_cnt, and sets rd_bank <= latest.
- FSM states IDLE, CMD, WAIT:
  - IDLE: if any side is eligible, register grant, cmd_write, cmd_addr and set cmd_valid; go to CMD on the next cycle. Grant to the sole eligible side; if both are eligible, grant the side not granted last (round-robin, writer first after reset).
  - CMD: hold cmd_valid, cmd_write and cmd_addr stable until cmd_ready. On the handshake cycle drop cmd_valid and go to WAIT.
  - WAIT: on burst_done, increment the granted side's counter and return to IDLE. Minimum one IDLE cycle between bursts.
- Address: cmd_addr = bank*BANK_STRIDE + cnt*BURST_LEN, computed at ADDR_W width with no wrap. cnt ranges 0..FRAME_WORDS/BURST_LEN-1.
- Write completion: on the burst_done that makes wr_cnt = FRAME_WORDS/BURST_LEN:
  - pulse frame_write_done;
  - latest <= wr_bank, latest_valid <= 1;
  - wr_bank <= 3 - wr_bank - rd_bank (the third bank);
  - writer disarms until the next wr_frame_start.
- Read completion: on the burst_done that makes rd_cnt = FRAME_WORDS/BURST_LEN, pulse frame_read_done and disarm the reader.
- Simultaneous write completion and rd_frame_start: rd_bank <= old wr_bank, wr_bank <= old rd_bank. The invariant wr_bank != rd_bank must hold on every cycle.
- Frame start during an in-flight burst of the same side: latch the start as pending and apply it on burst_done, after that burst's counter increment. The completion check uses the pre-restart count.
- wr_frame_start while the writer is mid-frame: the partial frame is abandoned, not published, bank unchanged, count restarts at 0. rd_frame_start mid-frame behaves the same way for the reader and re-selects latest.
- ddr_init_done falling: no new grants; an outstanding command completes normally.
- rst_n assertion mid-burst: asynchronous return to reset values. The engine is reset by the same rst_n.

Decomposition:
- Shared package ddr_frame_pkg holds:
  - the FSM state encoding;
  - BANK_W=2 and the constant FRAME_BURSTS = FRAME_WORDS/BURST_LEN;
  - a function third_bank(a,b) = 3-a-b.
- Sub-module frame_bank_ctrl handles bank rotation (wr_bank, rd_bank, latest, the simultaneous rule). The top-level block keeps the FSM, arbitration and counters.

Test Plan:
Tests use BURST_LEN=4, FRAME_WORDS=16, BANK_STRIDE=64, RD_FIFO_DEPTH=16.
- Reset, then ddr_init_done=1, wr_frame_start, wr_fifo_level=8, cmd_ready=1, burst_done 3 cycles after each handshake -> cmd_addr 0,4,8,12 with cmd_write=1; frame_write_done on the 4th burst_done; wr_bank 0->1; latest=0.
- Then rd_frame_start with rd_fifo_level=0 -> rd_bank=0; read addresses 0,4,8,12 with cmd_write=0; frame_read_done after the 4th burst.
- Both sides eligible continuously -> grants strictly alternate W,R,W,R; write addresses 64,68 (bank 1), read addresses 0,4.
- Hold cmd_ready=0 for 10 cycles -> cmd_valid, cmd_addr and cmd_write stay constant; exactly one handshake occurs.
- Force write completion and rd_frame_start on the same cycle (wr_bank=1, rd_bank=0) -> rd_bank=1, wr_bank=0; the two banks never equal.
- Pulse wr_frame_start during WAIT of write burst #2 -> the burst finishes, the next write address is the bank base, and no frame_write_done is produced. Assert rst_n low mid-WAIT -> all outputs return to reset values immediately.
